pixel_stream_bridge: RTL and testbench

PIXEL_STREAM_BRIDGE -- requirements
Module: pixel_stream_bridge

---
 rtl/pixel_stream_bridge_pkg.sv | 27 ++
 rtl/pixel_fifo.sv | 63 ++++++
 rtl/pixel_stream_bridge.sv | 163 ++++++++++++++++
 tb/tb_pixel_stream_bridge.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pixel_stream_bridge_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pixel_stream_bridge_pkg
// Brief    : Shared widths, FSM encoding and commit-entry helpers.
// Revision : 1.0 - initial release
// ============================================================================
package pixel_stream_bridge_pkg;

    localparam int c_PIX_W      = 12;
    localparam int c_ADDR_W     = 12;
    localparam int c_FIFO_DEPTH = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    // A commit entry is {pixel index, pixel value}, index in the upper bits.
    function automatic int entry_width(input int addr_w, input int pix_w);
        return addr_w + pix_w;
    endfunction

    localparam int c_ENTRY_W = entry_width(c_ADDR_W, c_PIX_W);

endpackage
`default_nettype wire

// File: rtl/pixel_fifo.sv
`default_nettype none
// ============================================================================
// Module   : pixel_fifo
// Brief    : Synchronous commit buffer; a push into a full buffer is accepted
//            when a pop happens in the same cycle, otherwise it is dropped.
// Revision : 1.0 - initial release
// ============================================================================
module pixel_fifo #(
    parameter int WIDTH = 24,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_head,
    output logic             o_full,
    output logic             o_empty,
    output logic             o_drop
);

    // DEPTH must be a power of two, at least 2.
    localparam int            c_AW      = $clog2(DEPTH);
    localparam logic [c_AW:0] c_PTR_ONE = {{c_AW{1'b0}}, 1'b1};

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_AW:0]    r_wr_ptr;
    logic [c_AW:0]    r_rd_ptr;
    logic             w_do_push;
    logic             w_do_pop;

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign o_empty   = (r_wr_ptr == r_rd_ptr);
    assign o_full    = (r_wr_ptr[c_AW] != r_rd_ptr[c_AW]) &&
                       (r_wr_ptr[c_AW-1:0] == r_rd_ptr[c_AW-1:0]);
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);
    assign o_drop    = i_push && o_full && !w_do_pop;
    assign o_head    = r_mem[r_rd_ptr[c_AW-1:0]];

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr[c_AW-1:0]] <= i_push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/pixel_stream_bridge.sv
`default_nettype none
// ============================================================================
// Module   : pixel_stream_bridge
// Brief    : Feeds ROM pixels to the processor and commits its output pixels
//            to a frame buffer each time the processor's pixel index moves.
// Revision : 1.0 - initial release
// ============================================================================
module pixel_stream_bridge
    import pixel_stream_bridge_pkg::*;
#(
    parameter int PIX_W      = c_PIX_W,
    parameter int ADDR_W     = c_ADDR_W,
    parameter int FIFO_DEPTH = c_FIFO_DEPTH
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] index,
    input  logic [PIX_W-1:0]  regout,
    output logic [ADDR_W-1:0] img_addr,
    output logic [ADDR_W-1:0] wtr_addr,
    input  logic [PIX_W-1:0]  img_data,
    input  logic [PIX_W-1:0]  wtr_data,
    output logic [PIX_W-1:0]  imagein,
    output logic [PIX_W-1:0]  waterin,
    output logic              fb_valid,
    input  logic              fb_ready,
    output logic [ADDR_W-1:0] fb_addr,
    output logic [PIX_W-1:0]  fb_data,
    output logic              busy,
    output logic              done,
    output logic              overflow,
    output logic [7:0]        frame_count
);

    localparam int c_ENT_W = entry_width(ADDR_W, PIX_W);

    state_t              r_state;
    state_t              w_next_state;
    logic [ADDR_W-1:0]   r_prev_index;
    logic [PIX_W-1:0]    r_imagein;
    logic [PIX_W-1:0]    r_waterin;
    logic                r_overflow;
    logic                r_done;
    logic [7:0]          r_frame_count;

    logic                w_run;
    logic                w_commit;
    logic                w_last;
    logic                w_pop;
    logic                w_full;
    logic                w_empty;
    logic                w_drop;
    logic                w_start_frame;
    logic                w_frame_end;
    logic [c_ENT_W-1:0]  w_push_data;
    logic [c_ENT_W-1:0]  w_head;

    assign w_run       = (r_state == ST_RUN);
    // Any index change commits the pixel produced for the previous index.
    assign w_commit    = w_run && (index != r_prev_index);
    assign w_last      = &r_prev_index;
    assign w_push_data = {r_prev_index, regout};
    assign w_pop       = fb_valid && fb_ready;

    pixel_fifo #(
        .WIDTH (c_ENT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_push      (w_commit),
        .i_push_data (w_push_data),
        .i_pop       (w_pop),
        .o_head      (w_head),
        .o_full      (w_full),
        .o_empty     (w_empty),
        .o_drop      (w_drop)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state  = r_state;
        w_start_frame = 1'b0;
        w_frame_end   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_next_state  = ST_RUN;
                    w_start_frame = 1'b1;
                end
            end
            ST_RUN: begin
                if (w_commit && w_last) begin
                    w_next_state = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (w_empty) begin
                    w_next_state = ST_IDLE;
                    w_frame_end  = 1'b1;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_prev_index  <= '0;
            r_overflow    <= 1'b0;
            r_done        <= 1'b0;
            r_frame_count <= 8'd0;
        end else begin
            r_done <= w_frame_end;
            if (w_start_frame || w_commit) begin
                r_prev_index <= index;
            end
            if (w_start_frame) begin
                r_overflow <= 1'b0;
            end else if (w_drop) begin
                r_overflow <= 1'b1;
            end
            if (w_frame_end) begin
                r_frame_count <= r_frame_count + 8'd1;
            end
        end
    end

    // ROM data lags its address by one cycle, so pixels land here two cycles after an index change.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_imagein <= '0;
            r_waterin <= '0;
        end else if (w_run) begin
            r_imagein <= img_data;
            r_waterin <= wtr_data;
        end
    end

    assign img_addr    = w_run ? index : '0;
    assign wtr_addr    = w_run ? index : '0;
    assign imagein     = r_imagein;
    assign waterin     = r_waterin;
    assign fb_valid    = !w_empty;
    assign fb_addr     = w_head[c_ENT_W-1 -: ADDR_W];
    assign fb_data     = w_head[PIX_W-1:0];
    assign busy        = (r_state != ST_IDLE);
    assign done        = r_done;
    assign overflow    = r_overflow;
    assign frame_count = r_frame_count;

endmodule
`default_nettype wire

// File: tb/tb_pixel_stream_bridge.sv
`default_nettype none
// ============================================================================
// Module   : tb_pixel_stream_bridge
// Brief    : Directed stimulus with a queue-based frame-buffer scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pixel_stream_bridge;
    import pixel_stream_bridge_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [11:0] index;
    logic [11:0] regout;
    logic [11:0] img_addr;
    logic [11:0] wtr_addr;
    logic [11:0] img_data;
    logic [11:0] wtr_data;
    logic [11:0] imagein;
    logic [11:0] waterin;
    logic        fb_valid;
    logic        fb_ready;
    logic [11:0] fb_addr;
    logic [11:0] fb_data;
    logic        busy;
    logic        done;
    logic        overflow;
    logic [7:0]  frame_count;

    int total = 0;
    int bad   = 0;
    int wr_cnt = 0;
    int exp_wr = 0;
    int done_cnt;
    logic [11:0] tb_prev = 12'd0;
    logic [c_ENTRY_W-1:0] exp_q [$];

    always #5 clk = ~clk;

    pixel_stream_bridge #(
        .PIX_W      (12),
        .ADDR_W     (12),
        .FIFO_DEPTH (4)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .index       (index),
        .regout      (regout),
        .img_addr    (img_addr),
        .wtr_addr    (wtr_addr),
        .img_data    (img_data),
        .wtr_data    (wtr_data),
        .imagein     (imagein),
        .waterin     (waterin),
        .fb_valid    (fb_valid),
        .fb_ready    (fb_ready),
        .fb_addr     (fb_addr),
        .fb_data     (fb_data),
        .busy        (busy),
        .done        (done),
        .overflow    (overflow),
        .frame_count (frame_count)
    );

    // Synchronous ROMs: one cycle of read latency.
    always @(posedge clk) begin
        img_data <= img_addr ^ 12'hAAA;
        wtr_data <= wtr_addr ^ 12'h555;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic commit(input logic [11:0] nidx, input logic [11:0] rv, input bit keep);
        regout = rv;
        index  = nidx;
        if (keep) begin
            exp_q.push_back({tb_prev, rv});
            exp_wr++;
        end
        tb_prev = nidx;
        tick();
    endtask

    // Monitor: pops the scoreboard on every frame-buffer handshake.
    initial begin : monitor
        logic                 stall;
        logic [11:0]          sa;
        logic [11:0]          sd;
        logic [c_ENTRY_W-1:0] e;
        stall = 1'b0;
        sa    = '0;
        sd    = '0;
        forever begin
            @(negedge clk);
            if (stall && fb_valid) begin
                check("stall_addr", {20'd0, fb_addr}, {20'd0, sa});
                check("stall_data", {20'd0, fb_data}, {20'd0, sd});
            end
            if (fb_valid && fb_ready) begin
                wr_cnt++;
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h, none expected", fb_addr, fb_data);
                end else begin
                    e = exp_q.pop_front();
                    check("fb_addr", {20'd0, fb_addr}, {20'd0, e[23:12]});
                    check("fb_data", {20'd0, fb_data}, {20'd0, e[11:0]});
                end
            end
            stall = fb_valid && !fb_ready;
            sa    = fb_addr;
            sd    = fb_data;
        end
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        rst_n    = 1'b0;
        start    = 1'b0;
        index    = 12'd0;
        regout   = 12'd0;
        fb_ready = 1'b1;
        repeat (3) tick();
        check("rst_fb_valid", {31'd0, fb_valid}, 0);
        check("rst_busy", {31'd0, busy}, 0);
        check("rst_done", {31'd0, done}, 0);
        check("rst_overflow", {31'd0, overflow}, 0);
        check("rst_frame_count", {24'd0, frame_count}, 0);
        check("rst_imagein", {20'd0, imagein}, 0);
        check("rst_waterin", {20'd0, waterin}, 0);
        check("idle_img_addr", {20'd0, img_addr}, 0);
        rst_n = 1'b1;

        // Basic commits: (0,F00) then (1,0F0)
        start = 1'b1;
        tb_prev = 12'd0;
        tick();
        start = 1'b0;
        check("run_busy", {31'd0, busy}, 1);
        regout = 12'hF00;
        tick();
        check("no_commit_same_index", {31'd0, fb_valid}, 0);
        commit(12'd1, 12'hF00, 1'b1);
        commit(12'd2, 12'h0F0, 1'b1);
        regout = 12'h00F;
        tick();

        // ROM latency: index 5 -> imagein 0xAAF two cycles later
        commit(12'd5, 12'h123, 1'b1);
        check("img_addr_comb", {20'd0, img_addr}, 32'h005);
        check("imagein_lat1", {20'd0, imagein}, 32'hAA8);
        tick();
        check("imagein_lat2", {20'd0, imagein}, 32'hAAF);
        check("waterin_lat2", {20'd0, waterin}, 32'h550);
        tick();

        // Overflow: five commits into a stalled four-entry buffer
        fb_ready = 1'b0;
        commit(12'd6, 12'h101, 1'b1);
        commit(12'd7, 12'h102, 1'b1);
        commit(12'd8, 12'h103, 1'b1);
        commit(12'd9, 12'h104, 1'b1);
        check("ovf_before_full_push", {31'd0, overflow}, 0);
        check("stall_head_addr", {20'd0, fb_addr}, 32'h005);
        check("stall_head_data", {20'd0, fb_data}, 32'h101);
        commit(12'd10, 12'h105, 1'b0);
        check("ovf_after_drop", {31'd0, overflow}, 1);
        tick();
        fb_ready = 1'b1;
        repeat (6) tick();
        check("ovf_sticky", {31'd0, overflow}, 1);
        check("drain_after_stall", exp_q.size(), 0);

        // Last index wraps the frame into DRAIN
        commit(12'd4094, 12'h0AA, 1'b1);
        commit(12'd4095, 12'h0BB, 1'b1);
        commit(12'd0, 12'h0CC, 1'b1);
        check("drain_busy", {31'd0, busy}, 1);
        check("drain_head_addr", {20'd0, fb_addr}, 32'hFFF);
        check("drain_fc_before", {24'd0, frame_count}, 0);
        done_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (done) begin
                done_cnt++;
                check("busy_at_done", {31'd0, busy}, 0);
                check("fc_at_done", {24'd0, frame_count}, 1);
            end
        end
        check("done_pulses", done_cnt, 1);
        check("fc_after_frame", {24'd0, frame_count}, 1);

        // Full buffer with a simultaneous pop accepts the push
        index   = 12'd0;
        tb_prev = 12'd0;
        start   = 1'b1;
        tick();
        start = 1'b0;
        check("start_clears_ovf", {31'd0, overflow}, 0);
        fb_ready = 1'b0;
        commit(12'd1, 12'h201, 1'b1);
        commit(12'd2, 12'h202, 1'b1);
        commit(12'd3, 12'h203, 1'b1);
        commit(12'd4, 12'h204, 1'b1);
        fb_ready = 1'b1;
        commit(12'd5, 12'h205, 1'b1);
        check("ovf_push_pop_full", {31'd0, overflow}, 0);
        repeat (8) tick();
        check("drain_after_pushpop", exp_q.size(), 0);

        // Reset mid-RUN discards pending entries; start ignored during reset
        fb_ready = 1'b0;
        commit(12'd6, 12'h301, 1'b1);
        commit(12'd7, 12'h302, 1'b1);
        commit(12'd8, 12'h303, 1'b1);
        check("pending_valid", {31'd0, fb_valid}, 1);
        rst_n  = 1'b0;
        start  = 1'b1;
        exp_wr = exp_wr - exp_q.size();
        exp_q.delete();
        tick();
        check("mid_rst_fb_valid", {31'd0, fb_valid}, 0);
        check("mid_rst_busy", {31'd0, busy}, 0);
        check("mid_rst_fc", {24'd0, frame_count}, 0);
        check("mid_rst_imagein", {20'd0, imagein}, 0);
        fb_ready = 1'b1;
        repeat (2) tick();
        check("rst_beats_start", {31'd0, busy}, 0);
        rst_n = 1'b1;
        start = 1'b0;
        repeat (4) tick();
        check("post_rst_fb_valid", {31'd0, fb_valid}, 0);
        check("post_rst_idle", {31'd0, busy}, 0);

        check("queue_empty", exp_q.size(), 0);
        check("write_count", wr_cnt, exp_wr);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
